// File: rtl/cell_test_pkg.sv
// cell_test_pkg: shared state encoding and defaults for the cell response capture path
package cell_test_pkg;
  localparam int DEF_CHANNELS = 8;
  localparam int DEF_CNT_W = 8;
  localparam int WIN_BASE = 16;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DRAIN} state_t;
endpackage

// File: rtl/cell_edge_counter.sv
// cell_edge_counter: one channel of synchroniser, prev flop, edge detect and saturating counter
module cell_edge_counter #(
  parameter int CNT_W = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  logic edge_hit;
  assign edge_hit = sync[SYNC_STAGES-1] ^ prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      prev  <= 1'b0;
      count <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], d};
      prev  <= sync[SYNC_STAGES-1];
      count <= clr ? '0 : (en && edge_hit && !(&count)) ? count + 1'b1 : count;
    end
  end
endmodule

// File: rtl/cell_response_capture.sv
// cell_response_capture: windowed per-channel transition counts streamed over valid/ready.
// Optional CELL_CAPTURE_STUCK_EN appends a stuck-channel mask word after the counts.
module cell_response_capture
  import cell_test_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [2:0]          win_sel,
  input  logic [CHANNELS-1:0] sample,
  output logic                busy,
  output logic [CNT_W-1:0]    dout,
  output logic [2:0]          dout_ch,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                done
);
`ifdef CELL_CAPTURE_STUCK_EN
  localparam int LAST = CHANNELS;
`else
  localparam int LAST = CHANNELS - 1;
`endif
  localparam int CH_W = $clog2(LAST + 1);
  localparam int IW = $clog2(CHANNELS);
  state_t state, state_n;
  logic [2:0] win_q, win_n;
  logic [11:0] timer, timer_n;
  logic [CH_W-1:0] ch, ch_n;
  logic done_n, hs, clr;
  logic [CNT_W-1:0] cnt [CHANNELS];
  logic [CNT_W-1:0] word;
  logic [2:0] word_ch;
  assign clr = abort | (state == IDLE && start);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    cell_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt (
      .clk(clk), .rst(rst), .d(sample[i]), .clr(clr),
      .en(state == MEASURE), .count(cnt[i])
    );
  end
`ifdef CELL_CAPTURE_STUCK_EN
  logic [CNT_W-1:0] mask;
  always_comb begin
    mask = '0;
    for (int i = 0; i < CHANNELS; i++) mask[i] = (cnt[i] == '0);
  end
  assign word = (ch == CH_W'(CHANNELS)) ? mask : cnt[ch[IW-1:0]];
  assign word_ch = (ch == CH_W'(CHANNELS)) ? 3'd7 : 3'(ch);
`else
  assign word = cnt[ch[IW-1:0]];
  assign word_ch = 3'(ch);
`endif
  assign busy = state != IDLE;
  assign dout_valid = state == DRAIN;
  assign dout = dout_valid ? word : '0;
  assign dout_ch = dout_valid ? word_ch : '0;
  assign hs = dout_valid & dout_ready;
  always_comb begin
    state_n = state;
    win_n = win_q;
    timer_n = timer;
    ch_n = ch;
    done_n = 1'b0;
    if (abort) begin
      state_n = IDLE;
      timer_n = '0;
      ch_n = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n = SETTLE;
          win_n = win_sel;
          timer_n = 12'(SYNC_STAGES - 1);
          ch_n = '0;
        end
        SETTLE: begin
          state_n = (timer == '0) ? MEASURE : SETTLE;
          timer_n = (timer == '0) ? 12'((WIN_BASE << win_q) - 1) : timer - 1'b1;
        end
        MEASURE: begin
          state_n = (timer == '0) ? DRAIN : MEASURE;
          timer_n = (timer == '0) ? timer : timer - 1'b1;
          ch_n = '0;
        end
        default: if (hs) begin
          state_n = (ch == CH_W'(LAST)) ? IDLE : DRAIN;
          done_n = ch == CH_W'(LAST);
          ch_n = (ch == CH_W'(LAST)) ? '0 : ch + 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      win_q <= '0;
      timer <= '0;
      ch    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      win_q <= win_n;
      timer <= timer_n;
      ch    <= ch_n;
      done  <= done_n;
    end
  end
endmodule
